// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port memory; optional MEM_ARB_FIXED_PRIO_EN makes master 0 win ties.
// Latency: request sampled at edge E, memory access in cycle E+1, ack pulse and read data in cycle E+2.
// Backpressure: a master holds req until its ack pulse; one access per two cycles, others wait in IDLE.
module mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          gnt_id
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_q;
    logic          m0_ack_q, m1_ack_q;
    logic [DW-1:0] m0_rdata_q, m1_rdata_q;
    logic [AW-1:0] cmd_addr_q, cmd_addr_d;
    logic          cmd_we_q, cmd_we_d;
    logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
    logic          gnt_id_q;

    logic elig0, elig1, pick1, any_elig;

    // A master whose ack is visible this cycle is masked so its held req is not re-granted.
    always_comb begin
        elig0    = m0_req & ~m0_ack_q;
        elig1    = m1_req & ~m1_ack_q;
        any_elig = elig0 | elig1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        pick1    = elig1 & ~elig0;
`else
        pick1    = elig1 & (~elig0 | ~gnt_id_q);
`endif
        cmd_we_d    = pick1 ? m1_we    : m0_we;
        cmd_addr_d  = pick1 ? m1_addr  : m0_addr;
        cmd_wdata_d = pick1 ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            cmd_addr_q  <= '0;
            cmd_we_q    <= 1'b0;
            cmd_wdata_q <= '0;
            gnt_id_q    <= 1'b1;
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_elig) begin
                        cmd_we_q    <= cmd_we_d;
                        cmd_addr_q  <= cmd_addr_d;
                        cmd_wdata_q <= cmd_wdata_d;
                        gnt_id_q    <= pick1;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (gnt_id_q) begin
                        m1_ack_q <= 1'b1;
                        if (!cmd_we_q) m1_rdata_q <= mem_dout;
                    end else begin
                        m0_ack_q <= 1'b1;
                        if (!cmd_we_q) m0_rdata_q <= mem_dout;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q == ACCESS);
    assign mem_addr = cmd_addr_q;
    assign mem_din  = cmd_wdata_q;
    assign mem_we   = cmd_we_q & busy;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign gnt_id   = gnt_id_q;

endmodule
